// File: rtl/calc_pkg.sv
// Shared calculator types: entry/convert FSM states and BCD digit constants.
package calc_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_entry_buffer.sv
// Shift-register BCD digit buffer: newest digit in slot 0, append/backspace/clear.
// Backspace logic exists only when ENTRY_BACKSPACE_EN is defined.
module bcd_entry_buffer
    import calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 6
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 append_i,
`ifdef ENTRY_BACKSPACE_EN
    input  logic                                 backspace_i,
`endif
    input  logic                                 clear_i,
    input  logic [DIGIT_W-1:0]                   digit_i,
    output logic [MAX_DIGITS-1:0][DIGIT_W-1:0]   bcd_o,
    output logic [2:0]                           count_o,
    output logic                                 full_o
);

    logic [MAX_DIGITS-1:0][DIGIT_W-1:0] bcd_q, bcd_d;
    logic [2:0]                         count_q, count_d;
    logic                               full_q, full_d;

    // Clear dominates; a full buffer silently drops appends.
    always_comb begin
        bcd_d   = bcd_q;
        count_d = count_q;
        if (clear_i) begin
            bcd_d   = '0;
            count_d = 3'd0;
`ifdef ENTRY_BACKSPACE_EN
        end else if (backspace_i) begin
            if (count_q != 3'd0) begin
                for (int i = 0; i < int'(MAX_DIGITS) - 1; i++) begin
                    bcd_d[i] = bcd_q[i+1];
                end
                bcd_d[MAX_DIGITS-1] = '0;
                count_d             = count_q - 3'd1;
            end
`endif
        end else if (append_i && !full_q) begin
            for (int i = int'(MAX_DIGITS) - 1; i > 0; i--) begin
                bcd_d[i] = bcd_q[i-1];
            end
            bcd_d[0] = digit_i;
            count_d  = count_q + 3'd1;
        end
        full_d = (count_d == 3'(MAX_DIGITS));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bcd_q   <= '0;
            count_q <= 3'd0;
            full_q  <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    assign bcd_o   = bcd_q;
    assign count_o = count_q;
    assign full_o  = full_q;

endmodule

// File: rtl/decimal_entry_collector.sv
// Signed decimal entry: strobe-driven BCD buffer plus serial BCD-to-binary converter.
// Optional backspace support is selected by the ENTRY_BACKSPACE_EN macro.
module decimal_entry_collector
    import calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 6,
    parameter int unsigned VALUE_W    = 40
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [DIGIT_W-1:0]            i_digit,
    input  logic                          i_digit_stb,
    input  logic                          i_backspace_stb,
    input  logic                          i_sign_stb,
    input  logic                          i_clear_stb,
    input  logic                          i_commit_stb,
    output logic [DIGIT_W*MAX_DIGITS-1:0] o_bcd,
    output logic [2:0]                    o_digit_count,
    output logic                          o_full,
    output logic                          o_busy,
    output logic [VALUE_W-1:0]            o_value,
    output logic                          o_sign,
    output logic                          o_valid,
    output logic                          o_err
);

    localparam int unsigned IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

    state_e                             state_q, state_d;
    logic [MAX_DIGITS-1:0][DIGIT_W-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [VALUE_W-1:0]                 acc_q, acc_d;
    logic [VALUE_W-1:0]                 value_q, value_d;
    logic                               psign_q, psign_d;
    logic                               csign_q, csign_d;
    logic                               sign_q, sign_d;
    logic                               valid_q, valid_d;
    logic                               err_q, err_d;
    logic                               busy_q, busy_d;

    logic                               buf_append, buf_clear, bs_eff;
    logic [MAX_DIGITS-1:0][DIGIT_W-1:0] bcd_w;

`ifdef ENTRY_BACKSPACE_EN
    logic buf_backspace;
    assign bs_eff = i_backspace_stb;
`else
    logic unused_backspace;
    assign unused_backspace = i_backspace_stb;
    assign bs_eff           = 1'b0;
`endif

    bcd_entry_buffer #(
        .MAX_DIGITS (MAX_DIGITS)
    ) u_buffer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .append_i    (buf_append),
`ifdef ENTRY_BACKSPACE_EN
        .backspace_i (buf_backspace),
`endif
        .clear_i     (buf_clear),
        .digit_i     (i_digit),
        .bcd_o       (bcd_w),
        .count_o     (o_digit_count),
        .full_o      (o_full)
    );

    // Entry strobe priority: clear > commit > backspace > digit > sign.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        value_d    = value_q;
        psign_d    = psign_q;
        csign_d    = csign_q;
        sign_d     = sign_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        buf_append = 1'b0;
        buf_clear  = 1'b0;
`ifdef ENTRY_BACKSPACE_EN
        buf_backspace = 1'b0;
`endif

        unique case (state_q)
            ENTRY: begin
                if (i_clear_stb) begin
                    buf_clear = 1'b1;
                    psign_d   = 1'b0;
                    err_d     = 1'b0;
                end else if (i_commit_stb) begin
                    state_d = CONVERT;
                    snap_d  = bcd_w;
                    csign_d = psign_q;
                    acc_d   = '0;
                    idx_d   = IDX_W'(MAX_DIGITS - 1);
                end else if (bs_eff) begin
`ifdef ENTRY_BACKSPACE_EN
                    buf_backspace = 1'b1;
`endif
                end else if (i_digit_stb) begin
                    if (i_digit > BCD_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        buf_append = 1'b1;
                    end
                end else if (i_sign_stb) begin
                    psign_d = ~psign_q;
                end
            end

            // Horner step, most significant slot first: acc*10 = acc*8 + acc*2.
            CONVERT: begin
                if (i_clear_stb) begin
                    state_d   = ENTRY;
                    buf_clear = 1'b1;
                    psign_d   = 1'b0;
                    err_d     = 1'b0;
                end else begin
                    acc_d = (acc_q << 3) + (acc_q << 1) + VALUE_W'(snap_q[idx_q]);
                    if (idx_q == '0) begin
                        state_d   = DONE;
                        value_d   = acc_d;
                        sign_d    = csign_q && (acc_d != '0);
                        valid_d   = 1'b1;
                        buf_clear = 1'b1;
                        psign_d   = 1'b0;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end

            DONE: begin
                state_d = ENTRY;
            end

            default: begin
                state_d = ENTRY;
            end
        endcase

        busy_d = (state_d != ENTRY);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ENTRY;
            snap_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            value_q <= '0;
            psign_q <= 1'b0;
            csign_q <= 1'b0;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            psign_q <= psign_d;
            csign_q <= csign_d;
            sign_q  <= sign_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign o_bcd   = bcd_w;
    assign o_busy  = busy_q;
    assign o_value = value_q;
    assign o_sign  = sign_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;

endmodule
